// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - instruction issue, ALU handshake and writeback controller for the 20-bit datapath
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [19:0] instr_data,
    output logic        instr_ready,
    output logic [3:0]  rf_ra_addr,
    output logic [3:0]  rf_rb_addr,
    input  logic [19:0] rf_ra_data,
    input  logic [19:0] rf_rb_data,
    output logic        rf_we,
    output logic [3:0]  rf_wa,
    output logic [19:0] rf_wd,
    output logic [5:0]  alu_op,
    output logic        alu_mode,
    output logic [19:0] alu_a,
    output logic [19:0] alu_b,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic [19:0] alu_result,
    input  logic [19:0] alu_result_b,
    input  logic        alu_zero,
    input  logic        alu_sign,
    input  logic        alu_carry,
    output logic [19:0] pc,
    output logic [12:0] status,
    output logic        trap
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_ADDR,
        S_EXEC,
        S_WB_A,
        S_WB_B
    } state_t;

    state_t      state_q, state_d;
    // Instruction word minus the ignored low five bits: {opcode, mode, ra, rb}
    logic [14:0] ir_q, ir_d;
    logic [19:0] pc_q, pc_d;
    // Live status bits {mode, trap, carry, sign, zero}; bits 12:5 of status are constant zero
    logic [4:0]  stat_q, stat_d;
    // High only during the first EXEC cycle so alu_start is a single pulse
    logic        first_q, first_d;
    logic [19:0] res_a_q, res_a_d;
    logic [19:0] res_b_q, res_b_d;

    logic [5:0]  op;
    logic        op_mode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        is_jump;
    logic        is_alu;
    logic        op_writes;
    logic        op_swap;
    logic        jump_taken;
    logic [19:0] status_word;

    assign op          = ir_q[14:9];
    assign op_mode     = ir_q[8];
    assign ra          = ir_q[7:4];
    assign rb          = ir_q[3:0];
    assign is_jump     = (op >= 6'h02) && (op <= 6'h05);
    assign is_alu      = (op >= 6'h08) && (op <= 6'h1B);
    assign op_writes   = (op >= 6'h08) && (op <= 6'h16);
    assign op_swap     = (op == 6'h10);
    assign status_word = {15'd0, stat_q};

    assign rf_ra_addr = ra;
    assign rf_rb_addr = rb;
    assign pc         = pc_q;
    assign status     = {8'd0, stat_q};
    assign trap       = stat_q[3];

    // Jump condition evaluated against the status held when the target word arrives
    always_comb begin
        jump_taken = 1'b0;
        case (op)
            6'h02:   jump_taken = 1'b1;
            6'h03:   jump_taken = stat_q[0];
            6'h04:   jump_taken = stat_q[1];
            6'h05:   jump_taken = stat_q[0] & stat_q[1];
            default: jump_taken = 1'b0;
        endcase
    end

    // Next-state, datapath updates and all handshake/writeback outputs
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        pc_d        = pc_q;
        stat_d      = stat_q;
        first_d     = 1'b0;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        rf_wa       = 4'd0;
        rf_wd       = 20'd0;
        alu_op      = 6'd0;
        alu_mode    = 1'b0;
        alu_a       = 20'd0;
        alu_b       = 20'd0;
        alu_start   = 1'b0;

        case (state_q)
            S_FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr_data[19:5];
                    pc_d    = pc_q + 20'd1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_jump) begin
                    state_d = S_FETCH_ADDR;
                end else if (is_alu) begin
                    first_d = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_FETCH;
                    if (op == 6'h06) begin
                        rf_we = 1'b1;
                        rf_wa = ra;
                        rf_wd = status_word;
                    end else if (op == 6'h07) begin
                        // XSTAT only acts while trapped; otherwise it is a NOP
                        if (stat_q[3]) begin
                            rf_we     = 1'b1;
                            rf_wa     = ra;
                            rf_wd     = rf_ra_data ^ status_word;
                            stat_d[3] = 1'b0;
                        end
                    end else if (op != 6'h01) begin
                        // TRAP and every illegal opcode raise the sticky trap flag
                        stat_d[3] = 1'b1;
                    end
                end
            end

            S_FETCH_ADDR: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    pc_d    = jump_taken ? instr_data : pc_q + 20'd1;
                    state_d = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_op    = op;
                alu_mode  = op_mode;
                alu_a     = rf_ra_data;
                alu_b     = rf_rb_data;
                alu_start = first_q;
                if (alu_done) begin
                    res_a_d     = alu_result;
                    res_b_d     = alu_result_b;
                    stat_d[2:0] = {alu_carry, alu_sign, alu_zero};
                    stat_d[4]   = op_mode;
                    state_d     = S_WB_A;
                end
            end

            S_WB_A: begin
                if (op_writes) begin
                    rf_we = 1'b1;
                    rf_wa = ra;
                    rf_wd = res_a_q;
                end
                state_d = op_swap ? S_WB_B : S_FETCH;
            end

            S_WB_B: begin
                rf_we   = 1'b1;
                rf_wa   = rb;
                rf_wd   = res_b_q;
                state_d = S_FETCH;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= 15'd0;
            pc_q    <= 20'd0;
            stat_q  <= 5'd0;
            first_q <= 1'b0;
            res_a_q <= 20'd0;
            res_b_q <= 20'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            first_q <= first_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
        end
    end

endmodule
